wb_cmd_master: RTL and testbench

Command-driven WISHBONE classic master that turns a debug-register command (address, data, direction, go, lock) into exactly one bus transaction on the TISC intercon's `wbvio` master port. It sits between the ChipScope VIO sync outputs and `tisc_intercon`. It handles ack/err/rty termination, bounded retry, optional bus lock across commands, and an optional bus timeout. Results (read data, done, error) go back to the VIO sync inputs.

---
 rtl/tisc_wb_pkg.sv | 15 +
 rtl/wb_cmd_timer.sv | 32 +++
 rtl/wb_cmd_master.sv | 154 +++++++++++++++
 tb/tb_wb_cmd_master.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tisc_wb_pkg.sv
// Shared WISHBONE constants and the command-master FSM state type for the TISC intercon.
package tisc_wb_pkg;

  localparam int unsigned WB_ADR_W = 21;
  localparam int unsigned WB_DAT_W = 32;
  localparam logic [3:0]  SEL_ALL  = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StBackoff,
    StLocked
  } wb_state_e;

endpackage

// File: rtl/wb_cmd_timer.sv
// Bus timeout counter: counts cycles while enabled and flags the cycle in which the
// TIMEOUT-th stb cycle completes without termination.
module wb_cmd_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CntW-1:0] r_cnt;
  logic            w_expired;

  assign w_expired = en_i && (r_cnt == CntLast);
  assign expired_o = w_expired;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && !w_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Command-driven WISHBONE classic master: one bus transaction per go rising edge, with
// bounded rty retry and optional bus lock. Define WB_CMD_TIMEOUT_EN to add a bus timeout.
module wb_cmd_master
  import tisc_wb_pkg::*;
#(
  parameter int unsigned ADR_W     = WB_ADR_W,
  parameter int unsigned DAT_W     = WB_DAT_W,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [DAT_W-1:0] cmd_dat_i,
  input  logic             cmd_we_i,
  input  logic             cmd_go_i,
  input  logic             cmd_lock_i,
  output logic [DAT_W-1:0] cmd_dat_o,
  output logic             cmd_done_o,
  output logic             cmd_err_o,
  output logic             cmd_busy_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  output logic [3:0]       sel_o,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             ack_i,
  input  logic             err_i,
  input  logic             rty_i
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  wb_state_e         r_state, w_state_nxt, w_exit;
  logic              r_go_q;
  logic              w_start, w_accept, w_timeout;
  logic [RetryW-1:0] r_retry, w_retry_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [DAT_W-1:0]  r_rd_dat, w_rd_dat_nxt;
  logic [ADR_W-1:0]  r_adr;
  logic [DAT_W-1:0]  r_dat;
  logic              r_we;

  assign w_start = cmd_go_i & ~r_go_q;
  assign w_exit  = cmd_lock_i ? StLocked : StIdle;

`ifdef WB_CMD_TIMEOUT_EN
  wb_cmd_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (r_state != StActive),
    .en_i     (r_state == StActive),
    .expired_o(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_retry_nxt  = r_retry;
    w_done_nxt   = r_done;
    w_err_nxt    = r_err;
    w_rd_dat_nxt = r_rd_dat;
    w_accept     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_accept = 1'b1;
      end
      StActive: begin
        // Timeout always releases the bus, even when lock is requested.
        if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end else if (err_i) begin
          w_err_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = w_exit;
        end else if (rty_i) begin
          if (r_retry < RetryMax) begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = StBackoff;
          end else begin
            w_err_nxt   = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = w_exit;
          end
        end else if (ack_i) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b0;
          if (!r_we) w_rd_dat_nxt = dat_i;
          w_state_nxt = w_exit;
        end
      end
      StBackoff: w_state_nxt = StActive;
      StLocked: begin
        if (w_start) w_accept = 1'b1;
        else if (!cmd_lock_i) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    if (w_accept) begin
      w_state_nxt = StActive;
      w_retry_nxt = '0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_go_q   <= 1'b0;
      r_retry  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rd_dat <= '0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_we     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_go_q   <= cmd_go_i;
      r_retry  <= w_retry_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_rd_dat <= w_rd_dat_nxt;
      if (w_accept) begin
        r_adr <= cmd_adr_i;
        r_dat <= cmd_dat_i;
        r_we  <= cmd_we_i;
      end
    end
  end

  assign cyc_o      = (r_state == StActive) || (r_state == StLocked);
  assign stb_o      = (r_state == StActive);
  assign cmd_busy_o = (r_state == StActive) || (r_state == StBackoff);
  assign we_o       = r_we;
  assign adr_o      = r_adr;
  assign dat_o      = r_dat;
  assign sel_o      = SEL_ALL;
  assign cmd_dat_o  = r_rd_dat;
  assign cmd_done_o = r_done;
  assign cmd_err_o  = r_err;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed and randomized commands against a
// transaction-level outcome model; the timeout section runs when WB_CMD_TIMEOUT_EN is defined.
module tb_wb_cmd_master;

  localparam int unsigned ADR_W     = 21;
  localparam int unsigned DAT_W     = 32;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned TIMEOUT   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ADR_W-1:0] cmd_adr = '0;
  logic [DAT_W-1:0] cmd_dat = '0;
  logic             cmd_we = 1'b0, cmd_go = 1'b0, cmd_lock = 1'b0;
  logic [DAT_W-1:0] cmd_dat_o;
  logic             done, err, busy, cyc, stb, we;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] wdat;
  logic [3:0]       sel;
  logic [DAT_W-1:0] sdat = '0;
  logic             ack = 1'b0, serr = 1'b0, rty = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [DAT_W-1:0] model_dat = '0;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .ADR_W(ADR_W), .DAT_W(DAT_W), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_we_i(cmd_we), .cmd_go_i(cmd_go),
    .cmd_lock_i(cmd_lock), .cmd_dat_o(cmd_dat_o), .cmd_done_o(done), .cmd_err_o(err),
    .cmd_busy_o(busy), .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(wdat),
    .sel_o(sel), .dat_i(sdat), .ack_i(ack), .err_i(serr), .rty_i(rty)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One command against a scripted slave: n_rty rty terminations, then ack (final_err=0)
  // or err (final_err=1); every burst waits a random count in [wmin, wmax] first.
  task automatic run_cmd(input logic [ADR_W-1:0] a, input logic [DAT_W-1:0] d, input bit w,
                         input bit lock, input int n_rty, input bit final_err,
                         input int wmin, input int wmax, input logic [DAT_W-1:0] rd);
    bit exp_err;
    int exp_bursts, burst, wait_left, bursts_seen, stb_cycles, gaps, busy_cycles, wait_sum;
    bit prev_stb, fin, first;
    exp_err    = (n_rty > int'(MAX_RETRY)) || final_err;
    exp_bursts = (n_rty > int'(MAX_RETRY)) ? int'(MAX_RETRY) + 1 : n_rty + 1;
    if (!exp_err && !w) model_dat = rd;
    burst = 0; bursts_seen = 0; stb_cycles = 0; gaps = 0; busy_cycles = 0;
    prev_stb = 0; fin = 0; first = 1;
    wait_left = $urandom_range(wmax, wmin);
    wait_sum  = wait_left;
    cmd_adr = a; cmd_dat = d; cmd_we = w; cmd_lock = lock; cmd_go = 1'b1;
    for (int n = 0; n < 300 && !fin; n++) begin
      @(negedge clk);
      if (first) begin
        check("start_latency_stb", stb, 1);
        check("done_cleared_at_start", done, 0);
        cmd_go = 1'b0;
        first = 0;
      end
      if (busy) busy_cycles++;
      if (busy && !cyc) gaps++;
      if (stb) begin
        if (!prev_stb) begin
          bursts_seen++;
          check("burst_adr", adr, a);
          check("burst_we", we, w);
          if (w) check("burst_dat", wdat, d);
        end
        stb_cycles++;
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          if (burst < n_rty) begin
            rty = 1'b1; ack = 1'($urandom);
          end else if (final_err) begin
            serr = 1'b1; ack = 1'($urandom); rty = 1'($urandom);
          end else begin
            ack = 1'b1; sdat = rd;
          end
          burst++;
          if (burst == exp_bursts) fin = 1;
          wait_left = $urandom_range(wmax, wmin);
          if (!fin) wait_sum += wait_left;
        end
      end
      prev_stb = stb;
      @(posedge clk);
      #1 ack = 1'b0; serr = 1'b0; rty = 1'b0; sdat = $urandom;
    end
    check("cmd_finished_in_budget", fin, 1);
    @(negedge clk);
    check("end_busy", busy, 0);
    check("end_done", done, 1);
    check("end_err", err, exp_err);
    check("end_cmd_dat", cmd_dat_o, model_dat);
    check("end_cyc_lock", cyc, lock);
    check("end_stb", stb, 0);
    check("burst_count", bursts_seen, exp_bursts);
    check("backoff_gaps", gaps, exp_bursts - 1);
    check("stb_cycles", stb_cycles, wait_sum + exp_bursts);
    check("busy_cycles", busy_cycles, wait_sum + 2 * exp_bursts - 1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd_dat", cmd_dat_o, 0);
    check("rst_sel", sel, 4'hF);
    check("rst_adr", adr, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // Write, zero wait; then 3-wait-state read
    run_cmd(21'h00008, 32'h3, 1'b1, 1'b0, 0, 1'b0, 0, 0, 32'h0);
    run_cmd(21'h00000, 32'h0, 1'b0, 1'b0, 0, 1'b0, 3, 3, 32'h54534331);
    // Retry twice then ack; retry four times exhausts
    run_cmd(21'h00010, 32'h0, 1'b0, 1'b0, 2, 1'b0, 0, 1, 32'hCAFE0001);
    run_cmd(21'h00014, 32'h0, 1'b0, 1'b0, 4, 1'b0, 0, 1, 32'hDEAD0002);
    check("err_keeps_cmd_dat", cmd_dat_o, 32'hCAFE0001);
    // Sticky results
    repeat (3) @(negedge clk);
    check("sticky_done", done, 1);
    check("sticky_err", err, 1);

    // Randomized commands
    for (int i = 0; i < 25; i++) begin
      run_cmd(ADR_W'($urandom), $urandom, 1'($urandom), 1'b0, $urandom_range(5, 0),
              ($urandom_range(3, 0) == 0), 0, 3, $urandom);
    end

    // Locked back-to-back reads
    run_cmd(21'h00020, 32'h0, 1'b0, 1'b1, 0, 1'b0, 0, 2, 32'h11112222);
    check("locked_gap_cyc", cyc, 1);
    check("locked_gap_stb", stb, 0);
    check("locked_gap_busy", busy, 0);
    run_cmd(21'h00024, 32'h0, 1'b0, 1'b1, 1, 1'b0, 0, 2, 32'h33334444);
    cmd_lock = 1'b0;
    @(negedge clk);
    check("unlock_cyc", cyc, 0);

    // Go edge while busy is ignored
    cmd_adr = 21'h00100; cmd_we = 1'b0; cmd_go = 1'b1;
    @(negedge clk) cmd_go = 1'b0;
    @(negedge clk) begin cmd_adr = 21'h001FF; cmd_go = 1'b1; end
    @(negedge clk);
    check("busy_go_adr", adr, 21'h00100);
    check("busy_go_busy", busy, 1);
    ack = 1'b1; sdat = 32'h0BADF00D; model_dat = 32'h0BADF00D;
    @(posedge clk) #1 ack = 1'b0;
    @(negedge clk);
    check("busy_go_done", done, 1);
    check("busy_go_dat", cmd_dat_o, model_dat);
    @(negedge clk);
    check("busy_go_no_restart", busy, 0);
    cmd_go = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-ACTIVE
    cmd_adr = 21'h00002; cmd_go = 1'b1;
    @(negedge clk) cmd_go = 1'b0;
    check("pre_rst_stb", stb, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cyc", cyc, 0);
    check("mid_rst_stb", stb, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    model_dat = '0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

`ifdef WB_CMD_TIMEOUT_EN
    begin
      int stb_cnt;
      stb_cnt = 0;
      cmd_adr = 21'h00030; cmd_we = 1'b0; cmd_lock = 1'b1; cmd_go = 1'b1;
      @(negedge clk) cmd_go = 1'b0;
      for (int n = 0; n < 100 && stb; n++) begin
        stb_cnt++;
        @(negedge clk);
      end
      check("timeout_stb_cycles", stb_cnt, TIMEOUT);
      check("timeout_err", err, 1);
      check("timeout_done", done, 1);
      check("timeout_cyc_ignores_lock", cyc, 0);
      check("timeout_cmd_dat", cmd_dat_o, model_dat);
      cmd_lock = 1'b0;
      @(negedge clk);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
